id_handler: RTL

//  First stage of the login chain; it feeds PasswordHandler. It collects a 4-digit
//  (16-bit) user ID from switches, one digit per button press. It then scans an

---
 rtl/id_handler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/id_handler.sv
// ---------------------------------------------------------------------------
// id_handler
// First stage of the login chain, feeding the password stage. A 4-digit
// (16-bit) user ID is collected from the switches, one digit per button
// press. A non-guest ID is then looked up by scanning an external ID ROM
// entry by entry. The first matching entry becomes the logged-in user. The
// result is held until the password stage pulses logout_from_pw.
//
// Ports
//   clk             in   1   system clock
//   rst             in   1   synchronous reset, active-low
//   id_switch       in   4   current ID digit
//   id_button       in   1   digit-enter strobe (single-cycle, debounced)
//   logout_from_pw  in   1   logout pulse from the password stage
//   rom_data        in   16  ID stored at rom_addr
//   rom_addr        out  5   ID ROM address, registered
//   matched_id      out  1   high while a valid ID is held
//   player_address  out  5   ROM index of the matched user, or GUEST_ADDR
//   is_guest        out  1   high with matched_id for the guest ID
//   id_rejected     out  1   one-cycle pulse when a scan finds no match
// ---------------------------------------------------------------------------
module id_handler #(
   parameter int          NUM_USERS   = 32,
   parameter int          ROM_LATENCY = 2,
   parameter logic [15:0] GUEST_ID    = 16'h0000,
   parameter logic [4:0]  GUEST_ADDR  = 5'd31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_switch,
   input  logic        id_button,
   input  logic        logout_from_pw,
   input  logic [15:0] rom_data,
   output logic [4:0]  rom_addr,
   output logic        matched_id,
   output logic [4:0]  player_address,
   output logic        is_guest,
   output logic        id_rejected
);

   // The wait counter only has to hold ROM_LATENCY-1.
   localparam int         CNT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
   localparam logic [4:0] LAST_IDX = 5'(NUM_USERS - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE,
      DIG2,
      DIG3,
      DIG4,
      SCAN_ISSUE,
      SCAN_WAIT,
      SCAN_CHECK,
      MATCHED
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      id_q, id_d;
   logic [4:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       romAddr_q, romAddr_d;
   logic [4:0]       playerAddr_q, playerAddr_d;
   logic             guest_q, guest_d;
   logic             rejected_q, rejected_d;

   // State and datapath registers. Reset abandons any entry or scan in
   // progress and clears every output, including the ROM address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         id_q         <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         romAddr_q    <= '0;
         playerAddr_q <= '0;
         guest_q      <= 1'b0;
         rejected_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         romAddr_q    <= romAddr_d;
         playerAddr_q <= playerAddr_d;
         guest_q      <= guest_d;
         rejected_q   <= rejected_d;
      end
   end

   // Next-state logic. A logout pulse overrides everything, including a
   // button press in the same cycle. Each ROM entry costs one issue cycle,
   // ROM_LATENCY wait cycles and one compare cycle. The ROM address is only
   // updated in SCAN_ISSUE, so it keeps its last value between scans.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      romAddr_d    = romAddr_q;
      playerAddr_d = playerAddr_q;
      guest_d      = guest_q;
      rejected_d   = 1'b0;

      if (logout_from_pw) begin
         state_d      = IDLE;
         playerAddr_d = '0;
         guest_d      = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (id_button) begin
                  id_d[15:12] = id_switch;
                  state_d     = DIG2;
               end
            end
            DIG2: begin
               if (id_button) begin
                  id_d[11:8] = id_switch;
                  state_d    = DIG3;
               end
            end
            DIG3: begin
               if (id_button) begin
                  id_d[7:4] = id_switch;
                  state_d   = DIG4;
               end
            end
            DIG4: begin
               if (id_button) begin
                  id_d[3:0] = id_switch;
                  if ({id_q[15:4], id_switch} == GUEST_ID) begin
                     state_d      = MATCHED;
                     guest_d      = 1'b1;
                     playerAddr_d = GUEST_ADDR;
                  end else begin
                     idx_d   = '0;
                     state_d = SCAN_ISSUE;
                  end
               end
            end
            SCAN_ISSUE: begin
               romAddr_d = idx_q;
               cnt_d     = CNT_LOAD;
               state_d   = SCAN_WAIT;
            end
            SCAN_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = SCAN_CHECK;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            SCAN_CHECK: begin
               if (rom_data == id_q) begin
                  state_d      = MATCHED;
                  playerAddr_d = idx_q;
                  guest_d      = 1'b0;
               end else if (idx_q == LAST_IDX) begin
                  rejected_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = SCAN_ISSUE;
               end
            end
            MATCHED: begin
               state_d = MATCHED;
            end
            default: begin
               state_d      = IDLE;
               playerAddr_d = '0;
               guest_d      = 1'b0;
            end
         endcase
      end
   end

   assign rom_addr       = romAddr_q;
   assign matched_id     = (state_q == MATCHED);
   assign player_address = playerAddr_q;
   assign is_guest       = guest_q;
   assign id_rejected    = rejected_q;

endmodule
